// File: rtl/lsu_pkg.sv
// lsu_pkg
//   Shared definitions for the load/store unit: FSM state encoding, RV32I
//   load/store funct3 codes and a misalignment helper used when a request
//   is captured.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } lsu_state_e;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } lsu_funct3_e;

   localparam logic [2:0] FUNCT3_B  = F3_B;
   localparam logic [2:0] FUNCT3_H  = F3_H;
   localparam logic [2:0] FUNCT3_W  = F3_W;
   localparam logic [2:0] FUNCT3_BU = F3_BU;
   localparam logic [2:0] FUNCT3_HU = F3_HU;

   // Byte accesses can never be misaligned; halves need addr[0]=0 and
   // everything else (words and undefined codes, which behave as words)
   // needs addr[1:0]=0.
   function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] a);
      logic mis;
      case (f3)
         FUNCT3_B, FUNCT3_BU: mis = 1'b0;
         FUNCT3_H, FUNCT3_HU: mis = a[0];
         default:             mis = (a != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
//   Purely combinational lane logic for the load/store unit.
//   Ports:
//     funct3   in  3   access type (undefined codes behave as word)
//     addr_lo  in  2   low byte-address bits of the access
//     st_data  in  32  store data from rs2
//     ld_word  in  32  word returned by memory
//     st_wdata out 32  store data replicated across the byte lanes
//     st_bmask out 4   byte-enable mask for the store
//     ld_data  out 32  selected and sign/zero-extended load value
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   input  logic [31:0] ld_word,
   output logic [31:0] st_wdata,
   output logic [3:0]  st_bmask,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Pick the addressed byte and half out of the returned word first, so the
   // extension step below only has to deal with the narrow value.
   always_comb begin
      ld_byte = ld_word[7:0];
      case (addr_lo)
         2'd0: ld_byte = ld_word[7:0];
         2'd1: ld_byte = ld_word[15:8];
         2'd2: ld_byte = ld_word[23:16];
         2'd3: ld_byte = ld_word[31:24];
         default: ld_byte = ld_word[7:0];
      endcase
      ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
   end

   // Store data is replicated into every lane so the mask alone decides which
   // bytes the memory writes; loads extend according to the signedness in
   // funct3.
   always_comb begin
      st_wdata = st_data;
      st_bmask = 4'b1111;
      ld_data  = ld_word;
      case (funct3)
         FUNCT3_B, FUNCT3_BU: begin
            st_wdata = {4{st_data[7:0]}};
            st_bmask = 4'b0001 << addr_lo;
            ld_data  = (funct3 == FUNCT3_B) ? {{24{ld_byte[7]}}, ld_byte}
                                            : {24'd0, ld_byte};
         end
         FUNCT3_H, FUNCT3_HU: begin
            st_wdata = {2{st_data[15:0]}};
            st_bmask = 4'b0011 << {addr_lo[1], 1'b0};
            ld_data  = (funct3 == FUNCT3_H) ? {{16{ld_half[15]}}, ld_half}
                                            : {16'd0, ld_half};
         end
         default: begin
            st_wdata = st_data;
            st_bmask = 4'b1111;
            ld_data  = ld_word;
         end
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl
//   RV32I load/store unit placed after the ALU. Captures one access, runs a
//   req/ack handshake with data memory, steers byte lanes and extends loads.
//   Misaligned accesses complete immediately with o_lsu_misalign and never
//   touch memory.
//   Optional feature: define LSU_TIMEOUT_EN to abort a request that is not
//   acknowledged within TIMEOUT_CYC cycles (adds port o_lsu_timeout).
//   Ports:
//     i_clk, i_rst_n             clock, synchronous active-low reset
//     i_lsu_valid/we/funct3      access request (sampled only when idle)
//     i_lsu_addr, i_lsu_wdata    byte address and store data
//     o_lsu_busy                 high while an access is in flight
//     o_lsu_done                 one-cycle completion pulse
//     o_lsu_rdata                extended load data, held until next load
//     o_lsu_misalign             with done: access was misaligned
//     o_mem_req/we/addr/wdata    memory request, word-aligned address
//     o_mem_bmask                byte enables (all ones for loads)
//     i_mem_ack, i_mem_rdata     memory completion and read data
//     o_lsu_timeout              with done: request timed out (LSU_TIMEOUT_EN)
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
`ifdef LSU_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 16
`endif
)
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_lsu_valid,
   input  logic              i_lsu_we,
   input  logic [2:0]        i_lsu_funct3,
   input  logic [31:0]       i_lsu_addr,
   input  logic [31:0]       i_lsu_wdata,
   output logic              o_lsu_busy,
   output logic              o_lsu_done,
   output logic [31:0]       o_lsu_rdata,
   output logic              o_lsu_misalign,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic [3:0]        o_mem_bmask,
   input  logic              i_mem_ack,
`ifdef LSU_TIMEOUT_EN
   output logic              o_lsu_timeout,
`endif
   input  logic [31:0]       i_mem_rdata
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_REQ  = REQ;
   localparam logic [1:0] ST_RESP = RESP;

   logic [1:0]  state;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        misalign_q;
   logic [31:0] rdata_q;
   logic        req_mis;

   logic [31:0] st_wdata;
   logic [3:0]  st_bmask;
   logic [31:0] ld_data;

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q;
   logic             timeout_q;
`endif

   assign req_mis = lsu_misaligned(i_lsu_funct3, i_lsu_addr[1:0]);

   lsu_align u_align (
      .funct3   (funct3_q),
      .addr_lo  (addr_q[1:0]),
      .st_data  (wdata_q),
      .ld_word  (i_mem_rdata),
      .st_wdata (st_wdata),
      .st_bmask (st_bmask),
      .ld_data  (ld_data)
   );

   // Main FSM. The request is captured once in IDLE so the core may change
   // its operands freely while we are busy. Misaligned requests skip REQ and
   // go straight to RESP. Load data is registered on the ack edge, which is
   // why it is visible together with done one cycle later.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= ST_IDLE;
         we_q       <= 1'b0;
         funct3_q   <= 3'd0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         misalign_q <= 1'b0;
         rdata_q    <= 32'd0;
`ifdef LSU_TIMEOUT_EN
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_lsu_valid) begin
                  we_q       <= i_lsu_we;
                  funct3_q   <= i_lsu_funct3;
                  addr_q     <= i_lsu_addr;
                  wdata_q    <= i_lsu_wdata;
                  misalign_q <= req_mis;
`ifdef LSU_TIMEOUT_EN
                  cnt_q      <= '0;
                  timeout_q  <= 1'b0;
`endif
                  state      <= req_mis ? ST_RESP : ST_REQ;
               end
            end
            ST_REQ: begin
               if (i_mem_ack) begin
                  if (!we_q) begin
                     rdata_q <= ld_data;
                  end
                  state <= ST_RESP;
               end
`ifdef LSU_TIMEOUT_EN
               else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                  timeout_q <= 1'b1;
                  state     <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
`endif
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from the state so everything reads zero in IDLE,
   // which keeps the memory bus quiet whenever no request is outstanding.
   always_comb begin
      o_lsu_busy     = (state != ST_IDLE);
      o_lsu_done     = (state == ST_RESP);
      o_lsu_misalign = o_lsu_done & misalign_q;
      o_lsu_rdata    = rdata_q;
      o_mem_req      = (state == ST_REQ);
      o_mem_we       = o_mem_req & we_q;
      o_mem_addr     = o_mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
      o_mem_wdata    = (o_mem_req & we_q) ? st_wdata : 32'd0;
      o_mem_bmask    = o_mem_req ? (we_q ? st_bmask : 4'b1111) : 4'b0000;
`ifdef LSU_TIMEOUT_EN
      o_lsu_timeout  = o_lsu_done & timeout_q;
`endif
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl
//   Directed bench for lsu_ctrl. A timeline model (what each output must be
//   in every cycle of an access, derived from access size and address
//   arithmetic) is compared against the DUT on every falling edge, and a few
//   literal values pin the model. With LSU_TIMEOUT_EN defined the timeout
//   path is exercised as well.
module tb_lsu_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_lsu_valid = 1'b0;
   logic        i_lsu_we = 1'b0;
   logic [2:0]  i_lsu_funct3 = 3'd0;
   logic [31:0] i_lsu_addr = 32'd0;
   logic [31:0] i_lsu_wdata = 32'd0;
   logic        i_mem_ack = 1'b0;
   logic [31:0] i_mem_rdata = 32'd0;

   logic        o_lsu_busy;
   logic        o_lsu_done;
   logic [31:0] o_lsu_rdata;
   logic        o_lsu_misalign;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_bmask;
`ifdef LSU_TIMEOUT_EN
   logic        o_lsu_timeout;
`endif

   lsu_ctrl dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_lsu_valid    (i_lsu_valid),
      .i_lsu_we       (i_lsu_we),
      .i_lsu_funct3   (i_lsu_funct3),
      .i_lsu_addr     (i_lsu_addr),
      .i_lsu_wdata    (i_lsu_wdata),
      .o_lsu_busy     (o_lsu_busy),
      .o_lsu_done     (o_lsu_done),
      .o_lsu_rdata    (o_lsu_rdata),
      .o_lsu_misalign (o_lsu_misalign),
      .o_mem_req      (o_mem_req),
      .o_mem_we       (o_mem_we),
      .o_mem_addr     (o_mem_addr),
      .o_mem_wdata    (o_mem_wdata),
      .o_mem_bmask    (o_mem_bmask),
      .i_mem_ack      (i_mem_ack),
`ifdef LSU_TIMEOUT_EN
      .o_lsu_timeout  (o_lsu_timeout),
`endif
      .i_mem_rdata    (i_mem_rdata)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   // Expected per-cycle behaviour, maintained by the stimulus.
   logic        exp_busy = 1'b0;
   logic        exp_req = 1'b0;
   logic        exp_done = 1'b0;
   logic        exp_misalign = 1'b0;
   logic        exp_timeout = 1'b0;
   logic        exp_mwe = 1'b0;
   logic [31:0] exp_rdata = 32'd0;
   logic [31:0] exp_maddr = 32'd0;
   logic [31:0] exp_mwdata = 32'd0;
   logic [3:0]  exp_bmask = 4'd0;

   // Last values seen on the memory bus, used for literal pins.
   logic        seen_req = 1'b0;
   logic [31:0] seen_addr = 32'd0;
   logic [31:0] seen_wdata = 32'd0;
   logic [3:0]  seen_bmask = 4'd0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Access size in bytes from funct3; undefined codes behave as words.
   function automatic int accSize(input logic [2:0] f3);
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
   endfunction

   function automatic logic [3:0] modelMask(input int s, input logic [31:0] a);
      logic [3:0] m = 4'd0;
      int off = int'(a % 32'd4);
      for (int i = 0; i < s; i++) begin
         if (off + i < 4) m[off + i] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [31:0] modelStoreData(input int s, input logic [31:0] w);
      logic [31:0] r = 32'd0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % s) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [31:0] a,
                                             input logic [2:0] f3);
      int s = accSize(f3);
      int off = int'(a % 32'd4);
      longint one = 1;
      longint v = (longint'(word) >> (8 * off)) & ((one << (8 * s)) - 1);
      if (s < 4 && !f3[2] && v >= (one << (8 * s - 1))) v = v - (one << (8 * s));
      return v[31:0];
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic setIdle();
      exp_busy = 1'b0;
      exp_req = 1'b0;
      exp_done = 1'b0;
      exp_misalign = 1'b0;
      exp_timeout = 1'b0;
   endtask

   // Cycle-by-cycle comparison against the model timeline.
   always @(negedge i_clk) begin
      if (chk_en) begin
         checkOutput("busy", 32'(o_lsu_busy), 32'(exp_busy));
         checkOutput("mem_req", 32'(o_mem_req), 32'(exp_req));
         checkOutput("done", 32'(o_lsu_done), 32'(exp_done));
         checkOutput("rdata", o_lsu_rdata, exp_rdata);
         if (exp_done) checkOutput("misalign", 32'(o_lsu_misalign), 32'(exp_misalign));
`ifdef LSU_TIMEOUT_EN
         if (exp_done) checkOutput("timeout", 32'(o_lsu_timeout), 32'(exp_timeout));
`endif
         if (exp_req) begin
            checkOutput("mem_addr", o_mem_addr, exp_maddr);
            checkOutput("mem_we", 32'(o_mem_we), 32'(exp_mwe));
            checkOutput("mem_bmask", 32'(o_mem_bmask), 32'(exp_bmask));
            if (exp_mwe) checkOutput("mem_wdata", o_mem_wdata, exp_mwdata);
         end
         if (o_mem_req) begin
            seen_req = 1'b1;
            seen_addr = o_mem_addr;
            seen_wdata = o_mem_wdata;
            seen_bmask = o_mem_bmask;
         end
      end
   end

   // One complete access. ackDelay is the number of REQ cycles before the ack
   // cycle. With noise set, stray valid/ack pulses are driven while busy.
   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int ackDelay,
                                input logic [31:0] rword, input logic noise);
      int s = accSize(f3);
      logic mis = ((addr % 32'(s)) != 32'd0);
      i_lsu_valid = 1'b1;
      i_lsu_we = we;
      i_lsu_funct3 = f3;
      i_lsu_addr = addr;
      i_lsu_wdata = wdata;
      setIdle();
      tick();
      i_lsu_valid = 1'b0;
      i_lsu_we = 1'($urandom);
      i_lsu_funct3 = 3'($urandom);
      i_lsu_addr = $urandom;
      i_lsu_wdata = $urandom;
      if (mis) begin
         exp_busy = 1'b1;
         exp_done = 1'b1;
         exp_misalign = 1'b1;
         tick();
         setIdle();
      end else begin
         exp_busy = 1'b1;
         exp_req = 1'b1;
         exp_maddr = addr & ~32'h3;
         exp_mwe = we;
         exp_bmask = we ? modelMask(s, addr) : 4'b1111;
         exp_mwdata = modelStoreData(s, wdata);
         for (int c = 0; c < ackDelay; c++) begin
            if (noise) begin
               i_lsu_valid = 1'b1;
               i_lsu_addr = $urandom;
            end
            tick();
         end
         i_mem_ack = 1'b1;
         i_mem_rdata = rword;
         tick();
         i_mem_ack = noise;
         i_lsu_valid = noise;
         i_mem_rdata = $urandom;
         exp_req = 1'b0;
         exp_done = 1'b1;
         exp_misalign = 1'b0;
         if (!we) exp_rdata = modelLoad(rword, addr, f3);
         tick();
         i_mem_ack = 1'b0;
         i_lsu_valid = 1'b0;
         setIdle();
      end
   endtask

   initial begin
      // Reset state.
      tick();
      tick();
      setIdle();
      exp_rdata = 32'd0;
      chk_en = 1'b1;
      @(negedge i_clk);
      checkOutput("rst_bmask", 32'(o_mem_bmask), 32'd0);
      checkOutput("rst_addr", o_mem_addr, 32'd0);
      checkOutput("rst_wdata", o_mem_wdata, 32'd0);
      checkOutput("rst_misalign", 32'(o_lsu_misalign), 32'd0);
      tick();
      i_rst_n = 1'b1;
      i_mem_ack = 1'b1;
      tick();
      i_mem_ack = 1'b0;
      tick();

      // SW, ack after two REQ cycles.
      applyStimulus(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'h0, 1'b0);
      checkOutput("sw_addr_lit", seen_addr, 32'h100);
      checkOutput("sw_bmask_lit", 32'(seen_bmask), 32'hF);
      checkOutput("sw_wdata_lit", seen_wdata, 32'hDEADBEEF);

      // Loads from word 0x8899AABB.
      applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h8899AABB, 1'b0);
      checkOutput("lb_lit", o_lsu_rdata, 32'hFFFFFF88);
      applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h8899AABB, 1'b1);
      checkOutput("lbu_lit", o_lsu_rdata, 32'h00000088);
      applyStimulus(1'b0, 3'b001, 32'h102, 32'h0, 3, 32'h8899AABB, 1'b0);
      checkOutput("lh_lit", o_lsu_rdata, 32'hFFFF8899);
      applyStimulus(1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h8899AABB, 1'b0);
      checkOutput("lhu_lit", o_lsu_rdata, 32'h00008899);
      applyStimulus(1'b0, 3'b000, 32'h101, 32'h0, 1, 32'h12345678, 1'b0);
      applyStimulus(1'b0, 3'b001, 32'h100, 32'h0, 0, 32'h1234F678, 1'b1);
      applyStimulus(1'b0, 3'b010, 32'h104, 32'h0, 2, 32'hCAFEF00D, 1'b0);
      applyStimulus(1'b0, 3'b011, 32'h108, 32'h0, 0, 32'h87654321, 1'b0);
      checkOutput("undef_w_lit", o_lsu_rdata, 32'h87654321);

      // Stores with lane steering.
      applyStimulus(1'b1, 3'b000, 32'h201, 32'h000000A5, 1, 32'h0, 1'b0);
      checkOutput("sb_wdata_lit", seen_wdata, 32'hA5A5A5A5);
      checkOutput("sb_bmask_lit", 32'(seen_bmask), 32'h2);
      applyStimulus(1'b1, 3'b001, 32'h202, 32'h1234BEEF, 0, 32'h0, 1'b1);
      checkOutput("sh_bmask_lit", 32'(seen_bmask), 32'hC);
      applyStimulus(1'b1, 3'b000, 32'h203, 32'h0000005A, 0, 32'h0, 1'b0);
      applyStimulus(1'b1, 3'b110, 32'h20C, 32'h01020304, 1, 32'h0, 1'b0);

      // Misaligned accesses never reach memory and keep rdata.
      seen_req = 1'b0;
      applyStimulus(1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0, 1'b0);
      checkOutput("mis_no_req", 32'(seen_req), 32'd0);
      checkOutput("mis_rdata_kept", o_lsu_rdata, 32'h87654321);
      applyStimulus(1'b1, 3'b001, 32'h203, 32'h0, 0, 32'h0, 1'b0);
      applyStimulus(1'b0, 3'b101, 32'h101, 32'h0, 0, 32'h0, 1'b0);

      // Reset while a request is outstanding.
      i_lsu_valid = 1'b1;
      i_lsu_we = 1'b0;
      i_lsu_funct3 = 3'b010;
      i_lsu_addr = 32'h300;
      tick();
      i_lsu_valid = 1'b0;
      exp_busy = 1'b1;
      exp_req = 1'b1;
      exp_mwe = 1'b0;
      exp_maddr = 32'h300;
      exp_bmask = 4'hF;
      tick();
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      setIdle();
      exp_rdata = 32'd0;
      tick();
      applyStimulus(1'b0, 3'b010, 32'h304, 32'h0, 1, 32'h55AA33CC, 1'b0);
      checkOutput("post_rst_lw_lit", o_lsu_rdata, 32'h55AA33CC);

`ifdef LSU_TIMEOUT_EN
      // No ack: abort after sixteen REQ cycles, late ack ignored.
      i_lsu_valid = 1'b1;
      i_lsu_we = 1'b0;
      i_lsu_funct3 = 3'b010;
      i_lsu_addr = 32'h400;
      tick();
      i_lsu_valid = 1'b0;
      exp_busy = 1'b1;
      exp_req = 1'b1;
      exp_mwe = 1'b0;
      exp_maddr = 32'h400;
      exp_bmask = 4'hF;
      repeat (16) tick();
      exp_req = 1'b0;
      exp_done = 1'b1;
      exp_misalign = 1'b0;
      exp_timeout = 1'b1;
      tick();
      setIdle();
      i_mem_ack = 1'b1;
      i_mem_rdata = 32'hFFFFFFFF;
      repeat (3) tick();
      i_mem_ack = 1'b0;
      tick();
`endif

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
